// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with fill level, almost flags, sticky overflow and high-water mark.
// Define SYNC_FIFO_REG_OUT_EN for a registered output stage; otherwise the head is read first-word-fall-through.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int PTR_WIDTH     = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    fill_cnt,
  output logic [PTR_WIDTH:0]    hwm,
  output logic                  overflow,
  input  logic                  clr_stat
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    cnt_q, cnt_d;
  logic [PTR_WIDTH:0]    hwm_q, hwm_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, rd_adv;
  logic                  full_w, empty_w;

`ifdef SYNC_FIFO_REG_OUT_EN
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;
  logic                  mem_empty;

  // Occupancy covers memory plus the output register, so the memory itself never overfills.
  always_comb begin
    full_w    = (cnt_q == DEPTH_C);
    empty_w   = (cnt_q == '0);
    mem_empty = (wr_ptr_q == rd_ptr_q);
    push      = wr_valid && !full_w;
    pop       = vld_q && rd_ready;
    rd_adv    = (!vld_q || rd_ready) && !mem_empty;
    vld_d     = vld_q;
    dout_d    = dout_q;
    if (rd_adv) begin
      vld_d  = 1'b1;
      dout_d = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign rd_valid = vld_q;
  assign rd_data  = dout_q;
`else
  always_comb begin
    full_w  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
              (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    empty_w = (wr_ptr_q == rd_ptr_q);
    push    = wr_valid && !full_w;
    pop     = !empty_w && rd_ready;
    rd_adv  = pop;
  end

  assign rd_valid = !empty_w;
  assign rd_data  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(rd_adv);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (clr_stat)
      hwm_d = cnt_d;
    else
      hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
    // A refused write in the same cycle as clr_stat still leaves overflow set.
    if (wr_valid && full_w)
      ovf_d = 1'b1;
    else if (clr_stat)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hwm_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hwm_q    <= hwm_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data;
  end

  assign wr_ready     = !full_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (cnt_q >= AFULL_C);
  assign almost_empty = (cnt_q <= AEMPTY_C);
  assign fill_cnt     = cnt_q;
  assign hwm          = hwm_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: expected read data is queued at stimulus time and checked by an
// independent monitor whenever a read handshake is seen; flags and counters are checked inline.
module tb_sync_fifo;

`ifdef SYNC_FIFO_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] fill_cnt, hwm;
  logic       overflow;
  logic       clr_stat;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  sync_fifo dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_cnt(fill_cnt), .hwm(hwm), .overflow(overflow), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fill_cnt"}, fill_cnt, 0);
    check({tag, " hwm"}, hwm, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " empty"}, empty, 1);
    check({tag, " almost_empty"}, almost_empty, 1);
    check({tag, " full"}, full, 0);
    check({tag, " wr_ready"}, wr_ready, 1);
    check({tag, " almost_full"}, almost_full, 0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    check({tag, " drain complete (entries left)"}, exp_q.size(), 0);
  endtask

  // Monitor: samples mid-cycle, where the handshake for the coming edge is stable.
  always @(negedge clk) begin
    if (rstn && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data unexpected: got %0h with nothing expected", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data != e) begin
          errors++;
          $display("FAIL rd_data order: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_stat = 1'b0;
    #12;
    check_reset_outputs("reset");
    tick();
    rstn = 1'b1;
    tick();

    // Fill to full with no reads.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h11 + 8'(i);
      exp_q.push_back(8'h11 + 8'(i));
      tick();
      check("fill fill_cnt", fill_cnt, i + 1);
      check("fill almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    wr_valid = 1'b0;
    check("fill full", full, 1);
    check("fill wr_ready", wr_ready, 0);
    check("fill hwm", hwm, 8);

    // Write into a full FIFO is refused and flagged.
    wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    check("ovf overflow", overflow, 1);
    check("ovf fill_cnt", fill_cnt, 8);
    tick();
    check("ovf sticky", overflow, 1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clr overflow", overflow, 0);
    check("clr hwm", hwm, 8);

    // Drain one word per cycle; monitor checks 0x11..0x18 order.
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain fill_cnt", fill_cnt, 7 - i);
      check("drain almost_empty", almost_empty, (7 - i <= 1) ? 1 : 0);
    end
    rd_ready = 1'b0;
    check("drain empty", empty, 1);
    check("drain rd_valid", rd_valid, 0);
    check("drain queue left", exp_q.size(), 0);

    // Steady push+pop at fill level 3, wrapping pointers.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h21 + 8'(i);
      exp_q.push_back(8'h21 + 8'(i));
      tick();
    end
    wr_valid = 1'b0;
    tick();
    check("stream start fill_cnt", fill_cnt, 3);
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      wr_data  = 8'h40 + 8'(i);
      exp_q.push_back(8'h40 + 8'(i));
      tick();
      check("stream fill_cnt", fill_cnt, 3);
    end
    wr_valid = 1'b0;
    drain("stream");

    // Latency from push into an empty FIFO.
    tick();
    check("lat empty", empty, 1);
    wr_valid = 1'b1; wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    wr_valid = 1'b0;
    check("lat rd_valid after 1", rd_valid, (LAT == 1) ? 1 : 0);
    tick();
    check("lat rd_valid after 2", rd_valid, 1);
    check("lat rd_data", rd_data, 8'hA5);
    drain("lat");

    // Asynchronous reset mid-stream discards everything.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h50 + 8'(i);
      exp_q.push_back(8'h50 + 8'(i));
      tick();
    end
    wr_valid = 1'b0;
    check("pre-reset fill_cnt", fill_cnt, 5);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    tick();
    rstn = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h3C;
    exp_q.push_back(8'h3C);
    tick();
    wr_valid = 1'b0;
    repeat (LAT) tick();
    check("post-reset rd_valid", rd_valid, 1);
    check("post-reset rd_data", rd_data, 8'h3C);
    drain("post-reset");
    tick();
    check("final empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
